// File: rtl/rr_interval_monitor.sv
// RR-interval monitor: synchronises a heartbeat pulse, measures beat-to-beat
// intervals in ms, keeps a running average and raises rhythm flags.
module rr_interval_monitor #(
  parameter int RR_W        = 12,
  parameter int AVG_LOG     = 3,
  parameter int REFRACT_MS  = 200,
  parameter int BRADY_MS    = 1500,
  parameter int TACHY_MS    = 500,
  parameter int DEV_SHIFT   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ms_tick,
  input  logic            pulse_in,
  input  logic            enable,
  output logic [RR_W-1:0] rr_ms,
  output logic            rr_valid,
  output logic [RR_W-1:0] avg_ms,
  output logic            avg_valid,
  output logic            brady,
  output logic            tachy,
  output logic            irregular,
  output logic            asystole
);

  localparam int DEPTH = 1 << AVG_LOG;
  localparam int SUM_W = RR_W + AVG_LOG;
  localparam logic [RR_W-1:0]    CNT_MAX   = {RR_W{1'b1}};
  localparam logic [RR_W-1:0]    REFRACT   = RR_W'(REFRACT_MS);
  localparam logic [RR_W-1:0]    BRADY_TH  = RR_W'(BRADY_MS);
  localparam logic [RR_W-1:0]    TACHY_TH  = RR_W'(TACHY_MS);
  localparam logic [AVG_LOG:0]   FILL_FULL = (AVG_LOG+1)'(DEPTH);
  localparam logic [AVG_LOG:0]   FILL_LAST = (AVG_LOG+1)'(DEPTH - 1);

  typedef enum logic {WAIT_FIRST, COUNTING} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_d;
  logic                 beat;
  logic [RR_W-1:0]      cnt;
  logic [RR_W-1:0]      rr_buf [DEPTH];
  logic [AVG_LOG-1:0]   wp;
  logic [SUM_W-1:0]     sum, sum_nxt;
  logic [AVG_LOG:0]     fill;
  logic                 sat, accept;
  logic [RR_W-1:0]      diff, dev_thr, avg_nxt;

  // The synchroniser runs regardless of enable so a pulse held across an
  // enable change cannot fabricate an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign beat = sync_q[SYNC_STAGES-1] & ~sync_d;

  always_comb begin
    state_nxt = state;
    sat       = (cnt == CNT_MAX);
    accept    = 1'b0;
    if (state == WAIT_FIRST) begin
      if (beat) state_nxt = COUNTING;
    end else begin
      accept = beat && (cnt >= REFRACT);
    end
    diff    = (cnt >= avg_ms) ? (cnt - avg_ms) : (avg_ms - cnt);
    dev_thr = avg_ms >> DEV_SHIFT;
    // Oldest entry drops out as the new one enters, so sum stays in range.
    sum_nxt = sum - {{AVG_LOG{1'b0}}, rr_buf[wp]} + {{AVG_LOG{1'b0}}, cnt};
    avg_nxt = sum_nxt[SUM_W-1:AVG_LOG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_FIRST;
      cnt       <= '0;
      wp        <= '0;
      sum       <= '0;
      fill      <= '0;
      rr_ms     <= '0;
      rr_valid  <= 1'b0;
      avg_ms    <= '0;
      avg_valid <= 1'b0;
      brady     <= 1'b0;
      tachy     <= 1'b0;
      irregular <= 1'b0;
      asystole  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rr_buf[i] <= '0;
    end else if (!enable) begin
      state     <= WAIT_FIRST;
      cnt       <= '0;
      wp        <= '0;
      sum       <= '0;
      fill      <= '0;
      rr_ms     <= '0;
      rr_valid  <= 1'b0;
      avg_ms    <= '0;
      avg_valid <= 1'b0;
      brady     <= 1'b0;
      tachy     <= 1'b0;
      irregular <= 1'b0;
      asystole  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rr_buf[i] <= '0;
    end else begin
      state    <= state_nxt;
      rr_valid <= 1'b0;
      if (accept) begin
        cnt       <= '0;
        rr_ms     <= cnt;
        rr_valid  <= 1'b1;
        tachy     <= (cnt < TACHY_TH);
        brady     <= (cnt > BRADY_TH) || sat;
        irregular <= !sat && avg_valid && (diff > dev_thr);
        asystole  <= 1'b0;
        // A saturated interval is not a real measurement; keep it out of the average.
        if (!sat) begin
          rr_buf[wp] <= cnt;
          wp         <= wp + 1'b1;
          sum        <= sum_nxt;
          avg_ms     <= avg_nxt;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
          if (fill == FILL_LAST) avg_valid <= 1'b1;
        end
      end else if (state == COUNTING) begin
        if (ms_tick && !sat) cnt <= cnt + 1'b1;
        if (sat) asystole <= 1'b1;
      end
    end
  end

endmodule
